if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0000, instruction word used for bubbles.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: imem_addr  output  32  instruction memory address; always equal to pc_addr.
REQ-006 Port: imem_rdata  input  32  instruction word for imem_addr, combinational from memory.
REQ-007 Port: imem_ready  input  1  imem_rdata valid this cycle.
REQ-008 Port: stall_d  input  1  hazard unit request to hold PC and IF/ID register.
REQ-009 Port: flush_d  input  1  request to replace IF/ID contents with a bubble.
REQ-010 Port: redirect_valid  input  1  taken branch/jump resolved downstream.
REQ-011 Port: redirect_target  input  32  new fetch address when redirect_valid.
REQ-012 Port: pc_addr  output  32  current fetch PC (registered).
REQ-013 Port: irF  output  32  fetched instruction: imem_rdata when imem_ready, else NOP_INSTR (combinational).
REQ-014 Port: irD  output  32  IF/ID registered instruction.
REQ-015 Port: pc_plus4D  output  32  IF/ID registered pc_addr+4 of irD.
REQ-016 Port: validD  output  1  irD holds a real instruction (0 = bubble).
REQ-017 Port: fetch_count  output  32  number of instructions loaded into IF/ID with validD=1.

Function
REQ-018 Next PC priority, highest first: rst -> RESET_PC; redirect_valid -> {redirect_target[31:2],2'b00}; stall_d -> hold; !imem_ready -> hold; else pc_addr+4.
REQ-019 PC increment wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no overflow flag.
REQ-020 IF/ID priority, highest first: rst -> bubble; flush_d or redirect_valid -> bubble; stall_d -> hold all IF/ID fields; !imem_ready -> bubble; else load irD=irF, pc_plus4D=pc_addr+4, validD=1.
REQ-021 Bubble = irD NOP_INSTR, pc_plus4D 0, validD 0.
REQ-022 Latency: instruction at PC accepted in cycle n appears on irD in cycle n+1.
REQ-023 flush_d with stall_d simultaneously: flush wins, PC still holds (unless redirect_valid).
REQ-024 redirect_valid with stall_d: redirect wins for both PC and IF/ID (older instruction has priority).
REQ-025 stall_d with imem_ready low: IF/ID holds (not bubbled), PC holds.
REQ-026 fetch_count increments by exactly 1 on each cycle IF/ID loads with validD=1; unchanged otherwise; wraps at 2^32.
REQ-027 No output depends combinationally on stall_d, flush_d or redirect_* (only irF depends on imem_*).

Reset
REQ-028 On rst=1 at a rising edge: pc_addr=RESET_PC, irD=NOP_INSTR, pc_plus4D=0, validD=0, fetch_count=0.
REQ-029 rst overrides every other input in the same cycle, including mid-stall and mid-redirect.
REQ-030 First cycle after rst deasserts fetches RESET_PC; irD valid earliest one cycle later.

Structure
REQ-031 RESET_PC default, NOP_INSTR and the 32-bit word width live in the shared CPU package used by all pipeline stages.
REQ-032 One sub-module: if_id_reg (IF/ID pipeline register with hold/bubble controls); PC and next-PC logic stay in if_stage.

Verification
REQ-033 Reset then 4 cycles, imem_ready=1, imem returns addr as data -> pc_addr 0,4,8,12; irD 0,4,8 one cycle behind; fetch_count 3.
REQ-034 stall_d=1 for 2 cycles at pc_addr=8 -> pc_addr stays 8, irD stays 4, fetch_count unchanged; resumes 12 after release.
REQ-035 redirect_valid=1, redirect_target=32'h0000_0103 with stall_d=1 -> next pc_addr=32'h0000_0100, validD=0, irD=NOP_INSTR.
REQ-036 imem_ready=0 for 3 cycles at pc_addr=16 -> PC holds 16, validD=0 each cycle; on ready, irD=instr@16, pc_plus4D=20.
REQ-037 PC at 32'hFFFF_FFFC, imem_ready=1 -> next pc_addr=32'h0000_0000, pc_plus4D=32'h0000_0000, validD=1.
REQ-038 rst asserted during stall with validD=1 -> next cycle all outputs at reset values per REQ-028.

Source files
------------

// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module : if_stage_pkg
// Brief  : Shared CPU pipeline definitions (word width, reset PC, bubble word).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam word_t PC_STEP           = 32'd4;

    // Action applied to a pipeline register in a given cycle.
    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctrl_t;

    // Fetch addresses are always word aligned.
    function automatic word_t pc_align(input word_t addr);
        pc_align = {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module : if_id_reg
// Brief  : IF/ID pipeline register with load/hold/bubble control and a
//          counter of valid instructions loaded.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import if_stage_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  ifid_ctrl_t ctrl,
    input  word_t      ir_in,
    input  word_t      pc_plus4_in,
    output word_t      ir,
    output word_t      pc_plus4,
    output logic       valid,
    output word_t      fetch_count
);

    word_t r_ir;
    word_t r_pc_plus4;
    logic  r_valid;
    word_t r_fetch_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir          <= NOP_INSTR;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            unique case (ctrl)
                IFID_LOAD: begin
                    r_ir          <= ir_in;
                    r_pc_plus4    <= pc_plus4_in;
                    r_valid       <= 1'b1;
                    r_fetch_count <= r_fetch_count + 32'd1;
                end
                IFID_BUBBLE: begin
                    r_ir       <= NOP_INSTR;
                    r_pc_plus4 <= '0;
                    r_valid    <= 1'b0;
                end
                default: begin
                    // hold: every field keeps its value
                end
            endcase
        end
    end

    assign ir          = r_ir;
    assign pc_plus4    = r_pc_plus4;
    assign valid       = r_valid;
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module : if_stage
// Brief  : Instruction fetch stage: PC register, next-PC selection and the
//          IF/ID pipeline register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEFAULT,
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    output word_t imem_addr,
    input  word_t imem_rdata,
    input  logic  imem_ready,
    input  logic  stall_d,
    input  logic  flush_d,
    input  logic  redirect_valid,
    input  word_t redirect_target,
    output word_t pc_addr,
    output word_t irF,
    output word_t irD,
    output word_t pc_plus4D,
    output logic  validD,
    output word_t fetch_count
);

    word_t      r_pc;
    word_t      w_pc_plus4;
    word_t      w_pc_next;
    ifid_ctrl_t w_ifid_ctrl;

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign w_pc_plus4 = r_pc + PC_STEP;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (redirect_valid) begin
            w_pc_next = pc_align(redirect_target);
        end else if (stall_d || !imem_ready) begin
            w_pc_next = r_pc;
        end
    end

    // A flush or redirect kills the younger instruction even while stalled.
    always_comb begin
        w_ifid_ctrl = IFID_LOAD;
        if (flush_d || redirect_valid) begin
            w_ifid_ctrl = IFID_BUBBLE;
        end else if (stall_d) begin
            w_ifid_ctrl = IFID_HOLD;
        end else if (!imem_ready) begin
            w_ifid_ctrl = IFID_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_addr   = r_pc;
    assign imem_addr = r_pc;
    assign irF       = imem_ready ? imem_rdata : NOP_INSTR;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (w_ifid_ctrl),
        .ir_in       (irF),
        .pc_plus4_in (w_pc_plus4),
        .ir          (irD),
        .pc_plus4    (pc_plus4D),
        .valid       (validD),
        .fetch_count (fetch_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module : tb_if_stage
// Brief  : Scoreboard bench for if_stage against a behavioural fetch model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall_d;
    logic        flush_d;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_addr;
    logic [31:0] irF;
    logic [31:0] irD;
    logic [31:0] pc_plus4D;
    logic        validD;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    bit scramble = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem(input logic [31:0] a, input bit scr);
        mem = scr ? (a ^ 32'h5A3C_0000) + {a[15:0], 16'h0} : a;
    endfunction

    assign imem_rdata = mem(imem_addr, scramble);

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_addr         (pc_addr),
        .irF             (irF),
        .irD             (irD),
        .pc_plus4D       (pc_plus4D),
        .validD          (validD),
        .fetch_count     (fetch_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] p4;
        logic        v;
        logic [31:0] cnt;
        logic [31:0] irf;
    } exp_t;

    exp_t q[$];

    // Reference state: architectural view of the fetch stage.
    logic [31:0] m_pc, m_ir, m_p4, m_cnt;
    logic        m_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rdy, input bit st, input bit fl,
                              input bit rv, input logic [31:0] tgt);
        logic [31:0] fetched;
        exp_t e;
        fetched = rdy ? mem(m_pc, scramble) : 32'h0;
        if (r) begin
            m_pc = 32'h0; m_ir = 32'h0; m_p4 = 32'h0; m_v = 1'b0; m_cnt = 32'h0;
        end else begin
            if (fl || rv) begin
                m_ir = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
            end else if (!st) begin
                if (rdy) begin
                    m_ir = fetched; m_p4 = m_pc + 32'd4; m_v = 1'b1; m_cnt = m_cnt + 1;
                end else begin
                    m_ir = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
                end
            end
            if (rv) m_pc = tgt & 32'hFFFF_FFFC;
            else if (!st && rdy) m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.ir = m_ir; e.p4 = m_p4; e.v = m_v; e.cnt = m_cnt;
        e.irf = rdy ? mem(m_pc, scramble) : 32'h0;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and record the expectation.
    task automatic cyc(input bit r, input bit rdy, input bit st, input bit fl,
                       input bit rv, input logic [31:0] tgt);
        @(negedge clk);
        rst = r; imem_ready = rdy; stall_d = st; flush_d = fl;
        redirect_valid = rv; redirect_target = tgt;
        model_step(r, rdy, st, fl, rv, tgt);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_addr", pc_addr, e.pc);
                chk("imem_addr", imem_addr, e.pc);
                chk("irD", irD, e.ir);
                chk("pc_plus4D", pc_plus4D, e.p4);
                chk("validD", {31'h0, validD}, {31'h0, e.v});
                chk("fetch_count", fetch_count, e.cnt);
                chk("irF", irF, e.irf);
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; imem_ready = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        m_pc = 32'h0; m_ir = 32'h0; m_p4 = 32'h0; m_v = 1'b0; m_cnt = 32'h0;

        // Sequential fetch from reset with memory returning its address.
        cyc(1, 1, 0, 0, 0, 0);
        settle();
        chk("reset_pc", pc_addr, 32'h0);
        chk("reset_valid", {31'h0, validD}, 32'h0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        // Two-cycle stall at PC 8.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        settle();
        chk("stall_pc", pc_addr, 32'd8);
        chk("stall_irD", irD, 32'd4);
        chk("stall_cnt", fetch_count, 32'd2);
        cyc(0, 1, 0, 0, 0, 0);
        settle();
        chk("resume_pc", pc_addr, 32'd12);
        chk("resume_cnt", fetch_count, 32'd3);
        cyc(0, 1, 0, 0, 0, 0);
        // Memory not ready for three cycles at PC 16.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        settle();
        chk("notready_pc", pc_addr, 32'd16);
        chk("notready_valid", {31'h0, validD}, 32'h0);
        cyc(0, 1, 0, 0, 0, 0);
        settle();
        chk("ready_irD", irD, 32'd16);
        chk("ready_p4", pc_plus4D, 32'd20);
        // Redirect beats stall; target is word aligned.
        cyc(0, 1, 1, 0, 1, 32'h0000_0103);
        settle();
        chk("redir_pc", pc_addr, 32'h0000_0100);
        chk("redir_valid", {31'h0, validD}, 32'h0);
        // Wrap of PC at the top of the address space.
        cyc(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 0, 0, 0);
        settle();
        chk("wrap_pc", pc_addr, 32'h0);
        chk("wrap_p4", pc_plus4D, 32'h0);
        chk("wrap_valid", {31'h0, validD}, 32'h1);
        // Reset while stalled with a valid instruction in IF/ID.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        settle();
        chk("rst_stall_pc", pc_addr, 32'h0);
        chk("rst_stall_irD", irD, 32'h0);
        chk("rst_stall_cnt", fetch_count, 32'h0);

        // Randomized traffic with a non-trivial memory image.
        scramble = 1'b1;
        for (int i = 0; i < 500; i++) begin
            bit r, rdy, st, fl, rv;
            logic [31:0] tgt;
            r   = ($urandom_range(99) < 2);
            rdy = ($urandom_range(99) < 80);
            st  = ($urandom_range(99) < 20);
            fl  = ($urandom_range(99) < 10);
            rv  = ($urandom_range(99) < 8);
            tgt = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                           : $urandom;
            cyc(r, rdy, st, fl, rv, tgt);
        end
        cyc(0, 1, 0, 0, 0, 0);

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
